// File: rtl/game_pkg.sv
// Shared types and default constants for the snake game step scheduler.
package game_pkg;

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        WAIT_TICK,
        STEP,
        WAIT_SNAKE,
        WAIT_FIELD,
        CHECK,
        WAIT_CHECK,
        PAUSED,
        DEAD
    } state_t;

    localparam int BASE_DIV_DEF = 8;
    localparam int LEVELS_DEF   = 8;
    localparam int TIMEOUT_DEF  = 4095;

    function automatic logic is_active(input state_t s);
        return s inside {WAIT_TICK, STEP, WAIT_SNAKE, WAIT_FIELD, CHECK, WAIT_CHECK};
    endfunction

    function automatic logic is_waiting(input state_t s);
        return s inside {WAIT_SNAKE, WAIT_FIELD, WAIT_CHECK};
    endfunction

endpackage

// File: rtl/game_sequencer_step_divider.sv
// Tick divider: counts ticks up to a level-dependent terminal count, then wraps.
module step_divider
    import game_pkg::*;
#(
    parameter int BASE_DIV = BASE_DIV_DEF,
    parameter int LVL_W    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             hold,
    input  logic             clear,
    input  logic [LVL_W-1:0] level,
    output logic             wrap
);

    localparam int CNT_W = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;

    logic [CNT_W-1:0] tick_cnt;
    logic [CNT_W-1:0] term;
    logic             count_en;

    // Terminal count is max(1, BASE_DIV-level)-1
    always_comb begin
        term = '0;
        if (BASE_DIV > int'(level) + 1)
            term = CNT_W'(BASE_DIV - int'(level) - 1);
    end

    assign count_en = tick && !hold;
    assign wrap     = count_en && (tick_cnt == term);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            tick_cnt <= '0;
        else if (clear || wrap)
            tick_cnt <= '0;
        else if (count_en)
            tick_cnt <= tick_cnt + 1'b1;
    end

endmodule

// File: rtl/game_sequencer.sv
// Snake game step scheduler: turns ticks into a handshaked step/rebuild/check
// sequence and owns game state, score, speed level and the handshake watchdog.
module game_sequencer
    import game_pkg::*;
#(
    parameter int BASE_DIV         = BASE_DIV_DEF,
    parameter int LEVELS           = LEVELS_DEF,
    parameter int APPLES_PER_LEVEL = 5,
    parameter int TIMEOUT          = TIMEOUT_DEF,
    parameter int SCORE_W          = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tick,
    input  logic                      start,
    input  logic                      pause,
    input  logic                      snake_done,
    input  logic                      field_done,
    input  logic                      check_done,
    input  logic                      hit_dead,
    input  logic                      hit_apple,
    output logic                      game_init,
    output logic                      snake_step,
    output logic                      check_req,
    output logic                      grow,
    output logic                      running,
    output logic                      dead,
    output logic [SCORE_W-1:0]        score,
    output logic [$clog2(LEVELS)-1:0] level,
    output logic                      err_timeout
);

    localparam int LVL_W = $clog2(LEVELS);
    localparam int APL_W = (APPLES_PER_LEVEL > 1) ? $clog2(APPLES_PER_LEVEL) : 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    localparam logic [LVL_W-1:0] LVL_MAX  = LVL_W'(LEVELS - 1);
    localparam logic [APL_W-1:0] APL_LAST = APL_W'(APPLES_PER_LEVEL - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    logic [APL_W-1:0] apple_cnt;
    logic [WD_W-1:0]  wdog;
    logic             step_wrap;
    logic             done_here;
    logic             timeout_fire;
    logic             apple_hit;

    step_divider #(
        .BASE_DIV (BASE_DIV),
        .LVL_W    (LVL_W)
    ) u_div (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .hold  ((state != WAIT_TICK) || pause),
        .clear (state_nxt == INIT),
        .level (level),
        .wrap  (step_wrap)
    );

    // A done pulse in the very cycle the watchdog expires still counts as on time
    assign done_here = ((state == WAIT_SNAKE) && snake_done) ||
                       ((state == WAIT_FIELD) && field_done) ||
                       ((state == WAIT_CHECK) && check_done);
    assign timeout_fire = is_waiting(state) && (wdog == WD_LAST) && !done_here;
    assign apple_hit    = (state == WAIT_CHECK) && check_done && !hit_dead && hit_apple;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:       if (start) state_nxt = INIT;
            INIT:       state_nxt = WAIT_TICK;
            WAIT_TICK: begin
                if (pause)          state_nxt = PAUSED;
                else if (step_wrap) state_nxt = STEP;
            end
            STEP:       state_nxt = WAIT_SNAKE;
            WAIT_SNAKE: begin
                if (snake_done)        state_nxt = WAIT_FIELD;
                else if (timeout_fire) state_nxt = DEAD;
            end
            WAIT_FIELD: begin
                if (field_done)        state_nxt = CHECK;
                else if (timeout_fire) state_nxt = DEAD;
            end
            CHECK:      state_nxt = WAIT_CHECK;
            WAIT_CHECK: begin
                if (check_done)        state_nxt = hit_dead ? DEAD : WAIT_TICK;
                else if (timeout_fire) state_nxt = DEAD;
            end
            PAUSED:     if (pause) state_nxt = WAIT_TICK;
            DEAD:       if (start) state_nxt = INIT;
            default:    state_nxt = IDLE;
        endcase
    end

    // Outputs decode the next state so every output is a plain register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            game_init   <= 1'b0;
            snake_step  <= 1'b0;
            check_req   <= 1'b0;
            grow        <= 1'b0;
            running     <= 1'b0;
            dead        <= 1'b0;
            score       <= '0;
            level       <= '0;
            err_timeout <= 1'b0;
            apple_cnt   <= '0;
            wdog        <= '0;
        end else begin
            state      <= state_nxt;
            game_init  <= (state_nxt == INIT);
            snake_step <= (state_nxt == STEP);
            check_req  <= (state_nxt == CHECK);
            running    <= is_active(state_nxt);
            dead       <= (state_nxt == DEAD);

            if (state_nxt != state)
                wdog <= '0;
            else if (is_waiting(state))
                wdog <= wdog + 1'b1;

            if (state_nxt == INIT) begin
                score       <= '0;
                level       <= '0;
                apple_cnt   <= '0;
                grow        <= 1'b0;
                err_timeout <= 1'b0;
            end else begin
                if (timeout_fire)
                    err_timeout <= 1'b1;
                if (state_nxt == STEP)
                    grow <= 1'b0;
                if (apple_hit) begin
                    grow <= 1'b1;
                    if (score != '1)
                        score <= score + 1'b1;
                    if (apple_cnt == APL_LAST) begin
                        apple_cnt <= '0;
                        if (level != LVL_MAX)
                            level <= level + 1'b1;
                    end else begin
                        apple_cnt <= apple_cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed scoreboard bench for game_sequencer: step timing, scoring, levels,
// pause, death, watchdog timeout and asynchronous reset.
module tb_game_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick = 1'b0, start = 1'b0, pause = 1'b0;
    logic        snake_done = 1'b0, field_done = 1'b0, check_done = 1'b0;
    logic        hit_dead = 1'b0, hit_apple = 1'b0;
    logic        game_init, snake_step, check_req, grow, running, dead, err_timeout;
    logic [15:0] score;
    logic [2:0]  level;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int score;
        int level;
        bit dead;
        bit grow;
    } exp_t;

    exp_t res_q[$];
    int   ticks_q[$];

    int m_score  = 0;
    int m_level  = 0;
    int m_apples = 0;
    bit m_grow   = 0;

    game_sequencer #(
        .BASE_DIV         (8),
        .LEVELS           (8),
        .APPLES_PER_LEVEL (5),
        .TIMEOUT          (4095),
        .SCORE_W          (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .start       (start),
        .pause       (pause),
        .snake_done  (snake_done),
        .field_done  (field_done),
        .check_done  (check_done),
        .hit_dead    (hit_dead),
        .hit_apple   (hit_apple),
        .game_init   (game_init),
        .snake_step  (snake_step),
        .check_req   (check_req),
        .grow        (grow),
        .running     (running),
        .dead        (dead),
        .score       (score),
        .level       (level),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int period();
        return (8 - m_level > 1) ? 8 - m_level : 1;
    endfunction

    task automatic pulse_in(input bit t, input bit s, input bit p);
        tick  = t;
        start = s;
        pause = p;
        cyc();
        tick  = 1'b0;
        start = 1'b0;
        pause = 1'b0;
    endtask

    task automatic reset_model();
        m_score  = 0;
        m_level  = 0;
        m_apples = 0;
        m_grow   = 0;
    endtask

    // Feed ticks (one every other cycle) until snake_step, bounded at 20 ticks
    task automatic wait_step(input int exp_ticks);
        int n = 0;
        bit got = 0;
        int exp_n;
        ticks_q.push_back(exp_ticks);
        chk("grow_held", grow, m_grow);
        for (int i = 0; i < 20 && !got; i++) begin
            pulse_in(1, 0, 0);
            n++;
            if (snake_step) got = 1;
            else cyc();
        end
        exp_n = ticks_q.pop_front();
        chk("step_ticks", got ? n : 0, exp_n);
        chk("grow_clear_on_step", grow, 0);
        m_grow = 0;
    endtask

    // From the STEP cycle through to the first WAIT_CHECK cycle
    task automatic handshake();
        repeat (3) cyc();
        snake_done = 1'b1;
        cyc();
        snake_done = 1'b0;
        repeat (2) cyc();
        field_done = 1'b1;
        cyc();
        field_done = 1'b0;
        chk("check_req", check_req, 1);
        cyc();
    endtask

    task automatic finish_check(input bit a, input bit d);
        exp_t e;
        repeat (2) cyc();
        hit_apple  = a;
        hit_dead   = d;
        check_done = 1'b1;
        if (!d && a) begin
            m_score++;
            m_grow = 1;
            m_apples++;
            if (m_apples == 5) begin
                m_apples = 0;
                if (m_level < 7) m_level++;
            end
        end
        e.score = m_score;
        e.level = m_level;
        e.dead  = d;
        e.grow  = m_grow;
        res_q.push_back(e);
        cyc();
        check_done = 1'b0;
        hit_apple  = 1'b0;
        hit_dead   = 1'b0;
        e = res_q.pop_front();
        chk("score", score, e.score);
        chk("level", level, e.level);
        chk("dead", dead, e.dead);
        chk("grow", grow, e.grow);
    endtask

    task automatic do_step(input int exp_ticks, input bit a, input bit d);
        wait_step(exp_ticks);
        handshake();
        finish_check(a, d);
    endtask

    initial begin
        #2ms;
        $display("FAIL global_time_limit observed=expired expected=finish");
        $fatal(1, "time limit");
    end

    initial begin
        int n;
        @(negedge clk);
        chk("reset_outputs",
            {game_init, snake_step, check_req, grow, running, dead, err_timeout, score, level}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        cyc();

        pulse_in(0, 1, 0);
        chk("init_pulse", game_init, 1);
        chk("init_not_running", running, 0);
        cyc();
        chk("init_one_cycle", game_init, 0);
        chk("running_after_init", running, 1);
        reset_model();

        for (int i = 0; i < 40; i++) do_step(period(), 1, 0);
        chk("level_saturated", level, 7);

        do_step(period(), 1, 1);
        chk("dead_not_running", running, 0);

        pulse_in(0, 1, 0);
        reset_model();
        chk("restart_init", game_init, 1);
        chk("restart_score", score, 0);
        chk("restart_level", level, 0);
        cyc();

        repeat (3) begin
            pulse_in(1, 0, 0);
            cyc();
        end
        pulse_in(0, 0, 1);
        chk("paused_not_running", running, 0);
        repeat (20) pulse_in(1, 1, 0);
        chk("paused_start_ignored", game_init, 0);
        chk("still_paused", running, 0);
        pulse_in(0, 0, 1);
        chk("resumed", running, 1);
        do_step(5, 0, 0);

        repeat (2) begin
            pulse_in(1, 0, 0);
            cyc();
        end
        pulse_in(1, 1, 1);
        chk("pause_beats_start", game_init, 0);
        chk("pause_beats_tick", running, 0);
        pulse_in(0, 0, 1);
        do_step(6, 0, 0);

        wait_step(8);
        repeat (3) cyc();
        snake_done = 1'b1;
        cyc();
        snake_done = 1'b0;
        n = 0;
        while (!dead && n < 5000) begin
            cyc();
            n++;
        end
        chk("timeout_cycles", n, 4095);
        chk("err_timeout_set", err_timeout, 1);
        chk("timeout_not_running", running, 0);

        pulse_in(0, 1, 0);
        reset_model();
        chk("err_timeout_cleared", err_timeout, 0);
        chk("restart2_init", game_init, 1);
        cyc();

        do_step(8, 1, 0);
        wait_step(8);
        handshake();
        chk("in_wait_check", running, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_reset_outputs",
            {game_init, snake_step, check_req, grow, running, dead, err_timeout, score, level}, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
